// File: rtl/ram_bus_arbiter.sv
// rtl/ram_bus_arbiter.sv - round-robin sharing of one synchronous RAM between the tv80n CPU and an aux master
//
// Purpose:
//   Arbitrates a single-port synchronous RAM between the CPU (decoded rd/wr
//   strobes, stretched through wait_n) and an auxiliary loader/DMA master
//   (req/gnt handshake). Ties alternate on the last served master. Each
//   access is a three-step sequence IDLE -> ISSUE (-> RESP for reads), so
//   only one access is ever outstanding. IDLE always sits between two accesses.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   cpu_rd, cpu_wr               decoded CPU strobes, held for the CPU cycle
//   cpu_addr, cpu_wdata          CPU address / write data
//   cpu_rdata                    registered read data to the CPU
//   cpu_wait_n                   0 stretches the current CPU cycle
//   aux_req, aux_we              aux request (held until aux_gnt), 1 = write
//   aux_addr, aux_wdata          aux address / write data
//   aux_gnt                      1-cycle pulse in the cycle the aux access hits the RAM
//   aux_rvalid, aux_rdata        1-cycle read-data strobe, data held until next aux read
//   ram_addr, ram_din            RAM address / write data
//   ram_rd, ram_we               RAM read / write enables (never both high)
//   ram_dout                     RAM read data, valid the cycle after ram_rd

module ram_bus_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_wait_n,
  input  logic                  aux_req,
  input  logic                  aux_we,
  input  logic [ADDR_WIDTH-1:0] aux_addr,
  input  logic [DATA_WIDTH-1:0] aux_wdata,
  output logic                  aux_gnt,
  output logic                  aux_rvalid,
  output logic [DATA_WIDTH-1:0] aux_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_rd,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_AUX = 1'b1;

  state_t state;
  state_t state_next;

  logic owner;       // master of the access in flight
  logic last_owner;  // master of the most recently retired access
  logic op_rd;       // access in flight is a read
  logic cpu_done;    // current CPU cycle already served
  logic cpu_live;    // CPU strobe has stayed high since its access was granted

  logic cpu_strobe;
  logic cpu_pend;
  logic grant_cpu;
  logic grant_aux;
  logic access_end;
  logic cpu_complete;

  assign cpu_strobe = cpu_rd | cpu_wr;
  assign cpu_pend   = cpu_strobe & ~cpu_done;

  // Combinational so the CPU is stretched in the very cycle its strobe rises.
  assign cpu_wait_n = ~cpu_pend;

  // A write retires as it leaves ISSUE, a read as it leaves RESP.
  assign access_end = ((state == ISSUE) && !op_rd) || (state == RESP);

  // Only credit the CPU if the strobe never dropped since the grant; an
  // abandoned access must not be mistaken for a later CPU cycle.
  assign cpu_complete = access_end && (owner == OWNER_CPU) && cpu_live && cpu_strobe;

  // RAM strobes and the aux grant exist only in ISSUE, which lasts one cycle.
  assign ram_rd  = (state == ISSUE) && op_rd;
  assign ram_we  = (state == ISSUE) && !op_rd;
  assign aux_gnt = (state == ISSUE) && (owner == OWNER_AUX);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_cpu  = 1'b0;
    grant_aux  = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the master that was not served last wins.
        if (cpu_pend && (!aux_req || (last_owner == OWNER_AUX))) begin
          grant_cpu  = 1'b1;
          state_next = ISSUE;
        end else if (aux_req) begin
          grant_aux  = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = op_rd ? RESP : IDLE;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      owner      <= OWNER_CPU;
      last_owner <= OWNER_AUX;
      op_rd      <= 1'b0;
      cpu_done   <= 1'b0;
      cpu_live   <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      cpu_rdata  <= '0;
      aux_rdata  <= '0;
      aux_rvalid <= 1'b0;
    end else begin
      aux_rvalid <= 1'b0;

      if (grant_cpu) begin
        owner    <= OWNER_CPU;
        ram_addr <= cpu_addr;
        ram_din  <= cpu_wdata;
        // A simultaneous rd+wr decode is treated as a write.
        op_rd    <= ~cpu_wr;
      end else if (grant_aux) begin
        owner    <= OWNER_AUX;
        ram_addr <= aux_addr;
        ram_din  <= aux_wdata;
        op_rd    <= ~aux_we;
      end

      if (grant_cpu) begin
        cpu_live <= 1'b1;
      end else if (!cpu_strobe) begin
        cpu_live <= 1'b0;
      end

      if (access_end) begin
        last_owner <= owner;
      end

      if (state == RESP) begin
        if (owner == OWNER_AUX) begin
          aux_rdata  <= ram_dout;
          aux_rvalid <= 1'b1;
        end else begin
          cpu_rdata <= ram_dout;
        end
      end

      // Strobe low ends the CPU cycle, re-arming service for the next one.
      if (!cpu_strobe) begin
        cpu_done <= 1'b0;
      end else if (cpu_complete) begin
        cpu_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// tb/tb_ram_bus_arbiter.sv - directed self-checking bench for ram_bus_arbiter

module tb_ram_bus_arbiter;

  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cpu_rd;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_wait_n;
  logic          aux_req;
  logic          aux_we;
  logic [AW-1:0] aux_addr;
  logic [DW-1:0] aux_wdata;
  logic          aux_gnt;
  logic          aux_rvalid;
  logic [DW-1:0] aux_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_rd;
  logic          ram_we;
  logic [DW-1:0] ram_dout;

  ram_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_wait_n (cpu_wait_n),
    .aux_req    (aux_req),
    .aux_we     (aux_we),
    .aux_addr   (aux_addr),
    .aux_wdata  (aux_wdata),
    .aux_gnt    (aux_gnt),
    .aux_rvalid (aux_rvalid),
    .aux_rdata  (aux_rdata),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_rd     (ram_rd),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM with a bench-side preload port.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pl_we;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    if (ram_we) mem[ram_addr] <= ram_din;
    if (ram_rd) ram_dout <= mem[ram_addr];
  end

  int   n_cmp = 0;
  int   n_bad = 0;
  int   excl_viol = 0;
  int   b2b_viol = 0;
  int   rd_cnt = 0;
  logic prev_issue = 1'b0;

  always @(negedge clk) begin
    if ((ram_rd === 1'b1) && (ram_we === 1'b1)) excl_viol++;
    if (prev_issue && ((ram_rd === 1'b1) || (ram_we === 1'b1))) b2b_viol++;
    prev_issue = (ram_rd === 1'b1) || (ram_we === 1'b1);
    if (ram_rd === 1'b1) rd_cnt++;
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int low;
    int gnts;
    int rd_base;
    logic seen;

    reset_n   = 1'b0;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    aux_req   = 1'b0;
    aux_we    = 1'b0;
    aux_addr  = '0;
    aux_wdata = '0;
    pl_we     = 1'b1;
    pl_addr   = 12'h123;
    pl_data   = 8'hA5;
    cyc();
    pl_we = 1'b0;
    cyc();

    // Reset values
    expect_eq("rst_wait_n",     32'(cpu_wait_n), 1);
    expect_eq("rst_ram_rd",     32'(ram_rd), 0);
    expect_eq("rst_ram_we",     32'(ram_we), 0);
    expect_eq("rst_aux_gnt",    32'(aux_gnt), 0);
    expect_eq("rst_aux_rvalid", 32'(aux_rvalid), 0);
    expect_eq("rst_cpu_rdata",  32'(cpu_rdata), 0);
    expect_eq("rst_aux_rdata",  32'(aux_rdata), 0);
    expect_eq("rst_ram_addr",   32'(ram_addr), 0);
    expect_eq("rst_ram_din",    32'(ram_din), 0);

    // 1: CPU read of 0x123 -> 0xA5; granted at the next edge
    reset_n  = 1'b1;
    cpu_rd   = 1'b1;
    cpu_addr = 12'h123;
    #1;
    expect_eq("t1_wait_same_cycle", 32'(cpu_wait_n), 0);
    cyc();
    expect_eq("t1_ram_rd",   32'(ram_rd), 1);
    expect_eq("t1_ram_we",   32'(ram_we), 0);
    expect_eq("t1_ram_addr", 32'(ram_addr), 32'h123);
    expect_eq("t1_wait_iss", 32'(cpu_wait_n), 0);
    cyc();
    expect_eq("t1_rd_one_cycle", 32'(ram_rd), 0);
    expect_eq("t1_wait_resp",    32'(cpu_wait_n), 0);
    cyc();
    expect_eq("t1_cpu_rdata", 32'(cpu_rdata), 32'hA5);
    expect_eq("t1_wait_done", 32'(cpu_wait_n), 1);
    cyc();
    expect_eq("t1_served_once", 32'(cpu_wait_n), 1);
    expect_eq("t1_rdata_stable", 32'(cpu_rdata), 32'hA5);
    expect_eq("t1_rd_count", rd_cnt, 1);
    cpu_rd = 1'b0;
    cyc();

    // 2: aux write 0x010 = 0x3C, then aux read back
    aux_req   = 1'b1;
    aux_we    = 1'b1;
    aux_addr  = 12'h010;
    aux_wdata = 8'h3C;
    cyc();
    expect_eq("t2w_gnt",      32'(aux_gnt), 1);
    expect_eq("t2w_ram_we",   32'(ram_we), 1);
    expect_eq("t2w_ram_rd",   32'(ram_rd), 0);
    expect_eq("t2w_ram_addr", 32'(ram_addr), 32'h010);
    expect_eq("t2w_ram_din",  32'(ram_din), 32'h3C);
    aux_req = 1'b0;
    cyc();
    expect_eq("t2w_gnt_pulse", 32'(aux_gnt), 0);
    expect_eq("t2w_we_pulse",  32'(ram_we), 0);
    aux_req = 1'b1;
    aux_we  = 1'b0;
    cyc();
    expect_eq("t2r_gnt",    32'(aux_gnt), 1);
    expect_eq("t2r_ram_rd", 32'(ram_rd), 1);
    aux_req = 1'b0;
    cyc();
    expect_eq("t2r_rvalid_early", 32'(aux_rvalid), 0);
    cyc();
    expect_eq("t2r_rvalid", 32'(aux_rvalid), 1);
    expect_eq("t2r_rdata",  32'(aux_rdata), 32'h3C);
    cyc();
    expect_eq("t2r_rvalid_pulse", 32'(aux_rvalid), 0);
    expect_eq("t2r_rdata_hold",   32'(aux_rdata), 32'h3C);

    // 3: tie after reset -> CPU first
    reset_n = 1'b0;
    cyc();
    reset_n   = 1'b1;
    cpu_wr    = 1'b1;
    cpu_addr  = 12'h001;
    cpu_wdata = 8'h11;
    aux_req   = 1'b1;
    aux_we    = 1'b1;
    aux_addr  = 12'h002;
    aux_wdata = 8'h22;
    cyc();
    expect_eq("t3a_cpu_we",   32'(ram_we), 1);
    expect_eq("t3a_cpu_addr", 32'(ram_addr), 32'h001);
    expect_eq("t3a_cpu_din",  32'(ram_din), 32'h11);
    expect_eq("t3a_no_gnt",   32'(aux_gnt), 0);
    cyc();
    expect_eq("t3a_wr_wait_done", 32'(cpu_wait_n), 1);
    cpu_wr = 1'b0;
    cyc();
    expect_eq("t3a_aux_gnt",  32'(aux_gnt), 1);
    expect_eq("t3a_aux_addr", 32'(ram_addr), 32'h002);
    aux_req = 1'b0;
    cyc();
    // lone CPU read of 0x001 confirms the write and leaves CPU as last owner
    cpu_rd   = 1'b1;
    cpu_addr = 12'h001;
    cyc();
    cyc();
    cyc();
    expect_eq("t3b_cpu_rdata", 32'(cpu_rdata), 32'h11);
    expect_eq("t3b_wait",      32'(cpu_wait_n), 1);
    cpu_rd = 1'b0;
    cyc();
    // repeat tie with CPU served last -> aux first
    cpu_wr    = 1'b1;
    cpu_addr  = 12'h003;
    cpu_wdata = 8'h33;
    aux_req   = 1'b1;
    aux_we    = 1'b1;
    aux_addr  = 12'h004;
    aux_wdata = 8'h44;
    #1;
    expect_eq("t3c_wait_c0", 32'(cpu_wait_n), 0);
    cyc();
    expect_eq("t3c_aux_first", 32'(aux_gnt), 1);
    expect_eq("t3c_aux_addr",  32'(ram_addr), 32'h004);
    aux_req = 1'b0;
    cyc();
    expect_eq("t3c_cpu_waiting", 32'(cpu_wait_n), 0);
    cyc();
    expect_eq("t3c_cpu_we",   32'(ram_we), 1);
    expect_eq("t3c_cpu_addr", 32'(ram_addr), 32'h003);
    expect_eq("t3c_cpu_din",  32'(ram_din), 32'h33);
    cyc();
    expect_eq("t3c_wait_done", 32'(cpu_wait_n), 1);
    cpu_wr = 1'b0;
    cyc();

    // 4: aux streams reads of 0x010; CPU read of 0x001 loses the tie once
    aux_req  = 1'b1;
    aux_we   = 1'b0;
    aux_addr = 12'h010;
    cpu_rd   = 1'b1;
    cpu_addr = 12'h001;
    #1;
    low  = 0;
    gnts = 0;
    for (int i = 0; i < 20; i++) begin
      if (cpu_wait_n) break;
      low++;
      if (aux_gnt) gnts++;
      @(posedge clk);
      #2;
    end
    expect_eq("t4_wait_cycles", low, 6);
    expect_eq("t4_aux_between", gnts, 1);
    expect_eq("t4_cpu_rdata",   32'(cpu_rdata), 32'h11);
    expect_eq("t4_aux_rdata",   32'(aux_rdata), 32'h3C);
    cpu_rd = 1'b0;
    seen   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (aux_gnt) begin
        seen = 1'b1;
        break;
      end
    end
    expect_eq("t4_aux_resumes", 32'(seen), 1);
    aux_req = 1'b0;
    cyc();
    cyc();
    cyc();

    // 5: reset during RESP of an aux read of 0x004
    aux_req  = 1'b1;
    aux_we   = 1'b0;
    aux_addr = 12'h004;
    cyc();
    expect_eq("t5_gnt", 32'(aux_gnt), 1);
    aux_req = 1'b0;
    cyc();
    reset_n = 1'b0;
    cyc();
    expect_eq("t5_no_rvalid",  32'(aux_rvalid), 0);
    expect_eq("t5_ram_rd",     32'(ram_rd), 0);
    expect_eq("t5_aux_rdata",  32'(aux_rdata), 0);
    expect_eq("t5_cpu_rdata",  32'(cpu_rdata), 0);
    expect_eq("t5_ram_addr",   32'(ram_addr), 0);
    expect_eq("t5_wait_n",     32'(cpu_wait_n), 1);
    reset_n  = 1'b1;
    cpu_rd   = 1'b1;
    cpu_addr = 12'h123;
    cyc();
    expect_eq("t5_cpu_issue",     32'(ram_rd), 1);
    expect_eq("t5_rvalid_after",  32'(aux_rvalid), 0);
    cyc();
    cyc();
    expect_eq("t5_cpu_rdata_new", 32'(cpu_rdata), 32'hA5);
    expect_eq("t5_wait_done",     32'(cpu_wait_n), 1);
    cpu_rd = 1'b0;
    cyc();

    // 6: CPU read abandoned in IDLE behind an aux write of 0x020 = 0x55
    aux_req   = 1'b1;
    aux_we    = 1'b1;
    aux_addr  = 12'h020;
    aux_wdata = 8'h55;
    cpu_rd    = 1'b1;
    cpu_addr  = 12'h123;
    cyc();
    expect_eq("t6_aux_gnt", 32'(aux_gnt), 1);
    aux_req = 1'b0;
    cyc();
    cpu_rd = 1'b0;
    #1;
    expect_eq("t6_wait_dropped", 32'(cpu_wait_n), 1);
    rd_base = rd_cnt;
    cyc();
    cyc();
    cyc();
    expect_eq("t6_no_cpu_read", rd_cnt - rd_base, 0);
    expect_eq("t6_wait_idle",   32'(cpu_wait_n), 1);
    cpu_rd   = 1'b1;
    cpu_addr = 12'h020;
    #1;
    expect_eq("t6_done_clear", 32'(cpu_wait_n), 0);
    cyc();
    cyc();
    cyc();
    expect_eq("t6_cpu_rdata", 32'(cpu_rdata), 32'h55);
    expect_eq("t6_wait_done", 32'(cpu_wait_n), 1);
    cpu_rd = 1'b0;
    cyc();

    expect_eq("rd_we_exclusive", excl_viol, 0);
    expect_eq("no_back_to_back", b2b_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
